data_sram_bridge: RTL



---
 rtl/data_sram_bridge_if.sv | 26 ++
 rtl/data_sram_bridge.sv | 108 ++++++++++
 2 files changed

// File: rtl/data_sram_bridge_if.sv
// Split-transaction SRAM-like bus between the data-side bridge and memory/cache.
// The bridge drives the request fields; the slave answers with addr_ok/data_ok/rdata.
interface data_sram_bridge_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [3:0]    wstrb;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_bridge.sv
// Turns one M-stage load/store into a single addr_ok/data_ok bus transaction and
// stalls the pipeline until the data phase completes.
module data_sram_bridge #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_en,
  input  logic [3:0]           cpu_wen,
  input  logic [1:0]           cpu_size,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  input  logic                 cpu_flush,
  input  logic                 cpu_longest_stall,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_stall,
  data_sram_bridge_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StHold} state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    wen_q, wen_d;
  logic [1:0]    size_q, size_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_en && !cpu_flush) begin
          addr_d  = cpu_addr;
          wen_d   = cpu_wen;
          size_d  = cpu_size;
          wdata_d = cpu_wdata;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (bus.addr_ok) state_d = StData;
      end
      StData: begin
        // A flush here cannot withdraw the transaction; it simply runs to data_ok.
        if (bus.data_ok) begin
          rdata_d = bus.rdata;
          state_d = cpu_longest_stall ? StHold : StIdle;
        end
      end
      StHold: begin
        if (!cpu_longest_stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Request valid is a flop so it never depends combinationally on addr_ok.
    req_d = (state_d == StAddr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wen_q   <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req   = req_q;
  assign bus.wr    = |wen_q;
  assign bus.size  = size_q;
  assign bus.addr  = addr_q;
  assign bus.wstrb = wen_q;
  assign bus.wdata = wdata_q;

  always_comb begin
    cpu_stall = 1'b0;
    unique case (state_q)
      StIdle:  cpu_stall = cpu_en & ~cpu_flush;
      StAddr:  cpu_stall = 1'b1;
      StData:  cpu_stall = ~bus.data_ok;
      StHold:  cpu_stall = 1'b0;
      default: cpu_stall = 1'b0;
    endcase
  end

  // Bypass so the M/W register samples the load value on the completion edge.
  assign cpu_rdata = (state_q == StData && bus.data_ok) ? bus.rdata : rdata_q;

endmodule
